// File: rtl/sss_seq_pkg.sv
// ============================================================================
// Module   : sss_seq_pkg
// Purpose  : Shared sequencer types and default sizes for note_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sss_seq_pkg;

    localparam int NUM_KEYS_DEF  = 17;
    localparam int NUM_STEPS_DEF = 16;

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_RECORD = 2'd1;
    localparam logic [1:0] C_ST_PLAY   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = C_ST_IDLE,
        RECORD = C_ST_RECORD,
        PLAY   = C_ST_PLAY
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_step_timer.sv
// ============================================================================
// Module   : seq_step_timer
// Purpose  : Step-boundary pulse generator, period STEP_TICKS*(tempo_sel+1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_step_timer #(
    parameter int STEP_TICKS = 1_200_000
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic       run,
    input  logic [1:0] tempo_sel,
    output logic       step_tick
);

    localparam int                  C_BASE_W    = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [C_BASE_W-1:0] C_BASE_LAST = C_BASE_W'(STEP_TICKS - 1);

    logic [C_BASE_W-1:0] r_base;
    logic [1:0]          r_sub;
    logic                w_base_wrap;

    assign w_base_wrap = run && (r_base == C_BASE_LAST);
    // ">=" lets a live tempo reduction fire on the very next base wrap
    assign step_tick   = w_base_wrap && (r_sub >= tempo_sel);

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            r_base <= '0;
            r_sub  <= '0;
        end else if (!run) begin
            r_base <= '0;
            r_sub  <= '0;
        end else if (w_base_wrap) begin
            r_base <= '0;
            r_sub  <= step_tick ? 2'd0 : r_sub + 2'd1;
        end else begin
            r_base <= r_base + C_BASE_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/note_sequencer.sv
// ============================================================================
// Module   : note_sequencer
// Purpose  : Key-bus arbiter with live pass-through, step recording and loop
//            playback. SEQ_LIVE_OVERLAY_EN mixes live keys into playback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_sequencer
    import sss_seq_pkg::*;
#(
    parameter int NUM_KEYS   = NUM_KEYS_DEF,
    parameter int NUM_STEPS  = NUM_STEPS_DEF,
    parameter int STEP_TICKS = 1_200_000
) (
    input  logic                         hwclk,
    input  logic                         reset,
    input  logic [NUM_KEYS-1:0]          live_keys,
    input  logic                         rec_btn,
    input  logic                         play_btn,
    input  logic                         clr_btn,
    input  logic [1:0]                   tempo_sel,
    output logic [NUM_KEYS-1:0]          synth_keys,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic [$clog2(NUM_STEPS):0]   pattern_len,
    output logic                         recording,
    output logic                         playing,
    output logic                         step_tick
);

    localparam int                 C_IDX_W    = $clog2(NUM_STEPS);
    localparam int                 C_LEN_W    = C_IDX_W + 1;
    localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(NUM_STEPS - 1);
    localparam logic [C_LEN_W-1:0] C_LEN_FULL = C_LEN_W'(NUM_STEPS);

    seq_state_t          r_state, w_state_next;
    logic                r_rec_prev, r_play_prev, r_clr_prev;
    logic                w_rec_ev, w_play_ev, w_clr_ev;
    logic [NUM_KEYS-1:0] r_acc, w_acc_or, w_acc_next;
    logic [NUM_KEYS-1:0] r_mem [NUM_STEPS];
    logic [C_IDX_W-1:0]  r_step_idx, w_idx_next;
    logic [C_LEN_W-1:0]  r_pattern_len, w_len_next;
    logic [NUM_KEYS-1:0] r_synth_keys, w_synth_next, w_play_word;
    logic                w_wr_en, w_mem_clr, w_run, w_tick;

    assign w_rec_ev  = rec_btn  & ~r_rec_prev;
    assign w_play_ev = play_btn & ~r_play_prev;
    assign w_clr_ev  = clr_btn  & ~r_clr_prev;
    assign w_acc_or  = r_acc | live_keys;

    // Any event that changes mode holds the timer for one cycle, restarting the step.
    assign w_run = (r_state != IDLE) && !w_clr_ev && !w_rec_ev
                   && !(w_play_ev && (r_state == PLAY));

    seq_step_timer #(
        .STEP_TICKS (STEP_TICKS)
    ) u_timer (
        .hwclk     (hwclk),
        .reset     (reset),
        .run       (w_run),
        .tempo_sel (tempo_sel),
        .step_tick (w_tick)
    );

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_step_idx;
        w_len_next   = r_pattern_len;
        w_acc_next   = '0;
        w_wr_en      = 1'b0;
        w_mem_clr    = 1'b0;
        if (w_clr_ev) begin
            w_mem_clr    = 1'b1;
            w_len_next   = '0;
            w_idx_next   = '0;
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rec_ev) begin
                        w_state_next = RECORD;
                        w_idx_next   = '0;
                    end else if (w_play_ev && (r_pattern_len != '0)) begin
                        w_state_next = PLAY;
                        w_idx_next   = '0;
                    end
                end
                RECORD: begin
                    w_acc_next = w_acc_or;
                    if (w_rec_ev) begin
                        w_wr_en      = 1'b1;
                        w_acc_next   = '0;
                        w_len_next   = {1'b0, r_step_idx} + C_LEN_W'(1);
                        w_idx_next   = '0;
                        w_state_next = IDLE;
                    end else if (w_tick) begin
                        w_wr_en    = 1'b1;
                        w_acc_next = '0;
                        w_idx_next = r_step_idx + C_IDX_W'(1);
                        if (r_step_idx == C_IDX_LAST) begin
                            w_len_next   = C_LEN_FULL;
                            w_state_next = IDLE;
                        end
                    end
                end
                PLAY: begin
                    if (w_rec_ev) begin
                        w_state_next = RECORD;
                        w_idx_next   = '0;
                    end else if (w_play_ev) begin
                        w_state_next = IDLE;
                    end else if (w_tick) begin
                        if ({1'b0, r_step_idx} == (r_pattern_len - C_LEN_W'(1)))
                            w_idx_next = '0;
                        else
                            w_idx_next = r_step_idx + C_IDX_W'(1);
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Reading at the next index lets playback show a new step the cycle after its tick.
`ifdef SEQ_LIVE_OVERLAY_EN
    assign w_play_word = r_mem[w_idx_next] | live_keys;
`else
    assign w_play_word = r_mem[w_idx_next];
`endif
    assign w_synth_next = (w_state_next == PLAY) ? w_play_word : live_keys;

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rec_prev    <= 1'b0;
            r_play_prev   <= 1'b0;
            r_clr_prev    <= 1'b0;
            r_acc         <= '0;
            r_step_idx    <= '0;
            r_pattern_len <= '0;
            r_synth_keys  <= '0;
        end else begin
            r_state       <= w_state_next;
            r_rec_prev    <= rec_btn;
            r_play_prev   <= play_btn;
            r_clr_prev    <= clr_btn;
            r_acc         <= w_acc_next;
            r_step_idx    <= w_idx_next;
            r_pattern_len <= w_len_next;
            r_synth_keys  <= w_synth_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_STEPS; gi++) begin : g_mem
            always_ff @(posedge hwclk or posedge reset) begin
                if (reset)
                    r_mem[gi] <= '0;
                else if (w_mem_clr)
                    r_mem[gi] <= '0;
                else if (w_wr_en && (r_step_idx == C_IDX_W'(gi)))
                    r_mem[gi] <= w_acc_or;
            end
        end
    endgenerate

    assign synth_keys  = r_synth_keys;
    assign step_idx    = r_step_idx;
    assign pattern_len = r_pattern_len;
    assign recording   = (r_state == RECORD);
    assign playing     = (r_state == PLAY);
    assign step_tick   = w_tick;

endmodule

`default_nettype wire

// File: tb/tb_note_sequencer.sv
// ============================================================================
// Module   : tb_note_sequencer
// Purpose  : Scoreboard bench for note_sequencer with STEP_TICKS = 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_note_sequencer;

    localparam int NK = 17;
    localparam int NS = 16;

    localparam int K_KEYS = 0;
    localparam int K_REC  = 1;
    localparam int K_PLAY = 2;
    localparam int K_LEN  = 3;
    localparam int K_TICK = 4;
    localparam int K_IDX  = 5;

`ifdef SEQ_LIVE_OVERLAY_EN
    localparam logic [16:0] OVL_S2   = 17'h10100;
    localparam logic [16:0] OVL_WRAP = 17'h10001;
`else
    localparam logic [16:0] OVL_S2   = 17'h00100;
    localparam logic [16:0] OVL_WRAP = 17'h00001;
`endif

    logic          hwclk     = 1'b0;
    logic          reset     = 1'b1;
    logic [NK-1:0] live_keys = '0;
    logic          rec_btn   = 1'b0;
    logic          play_btn  = 1'b0;
    logic          clr_btn   = 1'b0;
    logic [1:0]    tempo_sel = 2'd0;
    logic [NK-1:0] synth_keys;
    logic [3:0]    step_idx;
    logic [4:0]    pattern_len;
    logic          recording, playing, step_tick;

    note_sequencer #(
        .NUM_KEYS   (NK),
        .NUM_STEPS  (NS),
        .STEP_TICKS (4)
    ) dut (
        .hwclk       (hwclk),
        .reset       (reset),
        .live_keys   (live_keys),
        .rec_btn     (rec_btn),
        .play_btn    (play_btn),
        .clr_btn     (clr_btn),
        .tempo_sel   (tempo_sel),
        .synth_keys  (synth_keys),
        .step_idx    (step_idx),
        .pattern_len (pattern_len),
        .recording   (recording),
        .playing     (playing),
        .step_tick   (step_tick)
    );

    always #5 hwclk = ~hwclk;

    typedef struct {
        int          cyc;
        string       name;
        int          kind;
        logic [16:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [16:0] act;
    int          cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always @(posedge hwclk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input string nm, input int k, input logic [16:0] v);
        exp_t x;
        x.cyc  = c;
        x.name = nm;
        x.kind = k;
        x.val  = v;
        sb.push_back(x);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge hwclk);
            #1;
        end
    endtask

    // Monitor: pops every expectation due by this cycle and compares on the falling edge.
    always @(negedge hwclk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                K_KEYS:  act = synth_keys;
                K_REC:   act = {16'b0, recording};
                K_PLAY:  act = {16'b0, playing};
                K_LEN:   act = {12'b0, pattern_len};
                K_TICK:  act = {16'b0, step_tick};
                default: act = {13'b0, step_idx};
            endcase
            n_tests++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: got %h, expected %h", e.name, cyc, act, e.val);
            end
        end
    end

    initial begin
        goto(1);
        expect_at(1, "reset_keys", K_KEYS, 17'h0);
        expect_at(1, "reset_len",  K_LEN,  17'h0);
        expect_at(1, "reset_rec",  K_REC,  17'h0);
        expect_at(1, "reset_play", K_PLAY, 17'h0);
        expect_at(1, "reset_tick", K_TICK, 17'h0);
        expect_at(1, "reset_idx",  K_IDX,  17'h0);

        goto(2);
        reset = 1'b0; live_keys = 17'h00005;
        expect_at(2, "keys_before_edge", K_KEYS, 17'h0);
        expect_at(3, "live_passthru",    K_KEYS, 17'h00005);
        expect_at(3, "idle_rec",         K_REC,  17'h0);
        expect_at(3, "idle_play",        K_PLAY, 17'h0);

        // record: step0 = 0x1, step1 = 0x10, stop mid step2 holding 0x100
        goto(4);
        rec_btn = 1'b1; live_keys = 17'h00001;
        expect_at(5, "rec_enter", K_REC,  17'h1);
        expect_at(5, "rec_keys",  K_KEYS, 17'h00001);
        expect_at(5, "rec_idx0",  K_IDX,  17'h0);
        goto(5);
        rec_btn = 1'b0;
        expect_at(7, "rec_no_tick", K_TICK, 17'h0);
        expect_at(8, "rec_tick0",   K_TICK, 17'h1);
        goto(9);
        live_keys = 17'h00010;
        expect_at(9,  "rec_idx1",  K_IDX,  17'h1);
        expect_at(12, "rec_tick1", K_TICK, 17'h1);
        goto(13);
        live_keys = 17'h00100;
        expect_at(13, "rec_idx2", K_IDX, 17'h2);
        goto(14);
        rec_btn = 1'b1;
        expect_at(15, "rec_stop_mode", K_REC,  17'h0);
        expect_at(15, "rec_stop_len",  K_LEN,  17'h3);
        expect_at(15, "rec_stop_keys", K_KEYS, 17'h00100);
        goto(15);
        rec_btn = 1'b0; live_keys = 17'h0;
        expect_at(16, "idle_keys", K_KEYS, 17'h0);

        // playback, tempo 0
        goto(17);
        play_btn = 1'b1;
        expect_at(18, "play_enter", K_PLAY, 17'h1);
        expect_at(18, "play_s0",    K_KEYS, 17'h00001);
        expect_at(18, "play_idx0",  K_IDX,  17'h0);
        goto(18);
        play_btn = 1'b0;
        expect_at(20, "play_no_tick", K_TICK, 17'h0);
        expect_at(21, "play_tick0",   K_TICK, 17'h1);
        expect_at(21, "play_s0_hold", K_KEYS, 17'h00001);
        expect_at(22, "play_s1",      K_KEYS, 17'h00010);
        expect_at(22, "play_idx1",    K_IDX,  17'h1);
        expect_at(26, "play_s2",      K_KEYS, 17'h00100);
        expect_at(29, "play_tick2",   K_TICK, 17'h1);
        expect_at(30, "play_wrap",    K_KEYS, 17'h00001);
        expect_at(30, "play_wrap_idx", K_IDX, 17'h0);

        // tempo 2: period 12
        goto(30);
        tempo_sel = 2'd2;
        expect_at(33, "t2_no_tick_a", K_TICK, 17'h0);
        expect_at(37, "t2_no_tick_b", K_TICK, 17'h0);
        expect_at(41, "t2_tick_a",    K_TICK, 17'h1);
        expect_at(42, "t2_s1",        K_KEYS, 17'h00010);
        expect_at(53, "t2_tick_b",    K_TICK, 17'h1);
        expect_at(54, "t2_s2",        K_KEYS, 17'h00100);

        goto(55);
        live_keys = 17'h10000;
        expect_at(56, "overlay_s2",   K_KEYS, OVL_S2);
        expect_at(65, "t2_tick_c",    K_TICK, 17'h1);
        expect_at(66, "overlay_wrap", K_KEYS, OVL_WRAP);
        expect_at(66, "overlay_idx0", K_IDX,  17'h0);

        // clear beats record in the same cycle
        goto(67);
        clr_btn = 1'b1; rec_btn = 1'b1;
        expect_at(68, "clr_play", K_PLAY, 17'h0);
        expect_at(68, "clr_rec",  K_REC,  17'h0);
        expect_at(68, "clr_len",  K_LEN,  17'h0);
        expect_at(68, "clr_idx",  K_IDX,  17'h0);
        expect_at(68, "clr_keys", K_KEYS, 17'h10000);
        expect_at(68, "clr_tick", K_TICK, 17'h0);
        goto(68);
        clr_btn = 1'b0; rec_btn = 1'b0;
        goto(70);
        play_btn = 1'b1;
        expect_at(71, "empty_play_ignored", K_PLAY, 17'h0);
        expect_at(71, "empty_play_keys",    K_KEYS, 17'h10000);
        goto(71);
        play_btn = 1'b0;
        expect_at(73, "empty_play_still_idle", K_PLAY, 17'h0);

        // asynchronous reset in the middle of a recording
        goto(73);
        rec_btn = 1'b1;
        expect_at(74, "rec2_enter", K_REC, 17'h1);
        goto(74);
        rec_btn = 1'b0;
        goto(76);
        reset = 1'b1;
        expect_at(76, "async_rst_rec",  K_REC,  17'h0);
        expect_at(76, "async_rst_keys", K_KEYS, 17'h0);
        expect_at(76, "async_rst_len",  K_LEN,  17'h0);
        expect_at(76, "async_rst_idx",  K_IDX,  17'h0);
        expect_at(76, "async_rst_tick", K_TICK, 17'h0);
        goto(77);
        reset = 1'b0;
        expect_at(78, "post_rst_keys", K_KEYS, 17'h10000);
        expect_at(78, "post_rst_idle", K_REC,  17'h0);

        goto(82);
        n_tests++;
        if (synth_keys !== 17'h10000) begin
            n_fail++;
            $display("FAIL final_keys: got %h", synth_keys);
        end
        n_tests++;
        if (playing !== 1'b0) begin
            n_fail++;
            $display("FAIL final_play: got %b", playing);
        end
        n_tests++;
        if (pattern_len !== 5'd0) begin
            n_fail++;
            $display("FAIL final_len: got %h", pattern_len);
        end
        n_tests++;
        if (step_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL final_idx: got %h", step_idx);
        end
        n_tests++;
        if (step_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL final_tick: got %b", step_tick);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: expectation for cyc %0d never checked (now %0d)", e.name, e.cyc, cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/note_sequencer.md
# note_sequencer

Step sequencer and key-bus arbiter in front of the synthesizer. Owns the synth's 17-bit key input. Either passes the live push-button keys straight through, records them into a step pattern, or plays the stored pattern back in a loop. Sits between the top-level `pb` inputs and the synthesizer instance.

## Interface
Parameters:
- `NUM_KEYS`, 17, width of key bus
- `NUM_STEPS`, 16, pattern depth (power of two)
- `STEP_TICKS`, 1_200_000, `hwclk` cycles per base step (100 ms at 12 MHz)

Ports (clock and reset first):
- `hwclk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `live_keys`  in  NUM_KEYS  debounced, synchronized key levels
- `rec_btn`, `play_btn`, `clr_btn`  in  1 each  level buttons; edge-detected internally
- `tempo_sel`  in  2  step period = STEP_TICKS × (tempo_sel+1)
- `synth_keys`  out  NUM_KEYS  registered key bus to the synthesizer
- `step_idx`  out  $clog2(NUM_STEPS)  current step
- `pattern_len`  out  $clog2(NUM_STEPS)+1  stored steps, 0..NUM_STEPS
- `recording`, `playing`  out  1 each  state indicators
- `step_tick`  out  1  one-cycle pulse at each step boundary

## Operation
- States: IDLE, RECORD, PLAY.
- Button events are rising edges: previous value registered, event = btn & ~prev.
- Priority for same-cycle events: clr > rec > play.
- clr (any state):
  - all pattern memory cleared to 0
  - pattern_len = 0, step_idx = 0
  - step timer reset
  - → IDLE
- IDLE:
  - synth_keys ← live_keys
  - rec → RECORD, step_idx = 0, accumulator = 0, timer reset
  - play with pattern_len ≠ 0 → PLAY, step_idx = 0, timer reset
  - play with pattern_len = 0 is ignored
- RECORD:
  - synth_keys ← live_keys
  - accumulator ORs in live_keys every cycle
  - At each step_tick: mem[step_idx] ← accumulator, accumulator cleared, step_idx+1.
  - On the tick that writes step NUM_STEPS-1: pattern_len = NUM_STEPS, → IDLE.
  - rec event mid-step: the partial accumulator is written to mem[step_idx], pattern_len = step_idx+1, → IDLE.
  - play event in RECORD is ignored.
- PLAY:
  - synth_keys ← mem[step_idx] (live overlay: see Configuration)
  - step_tick advances step_idx; wraps from pattern_len-1 to 0
  - play event → IDLE
  - rec event → RECORD from step 0; the pattern is overwritten
- Step timer:
  - base counter runs 0..STEP_TICKS-1
  - sub-counter counts base wraps 0..tempo_sel
  - step_tick fires when both counters are at terminal values
  - tempo_sel is sampled live; if a change leaves sub-counter > tempo_sel, the next base wrap fires the tick
  - the timer runs only in RECORD/PLAY and is held at 0 in IDLE

## Timing
- Reset values:
  - synth_keys = 0, step_idx = 0, pattern_len = 0
  - recording = 0, playing = 0, step_tick = 0
  - pattern memory all 0
  - state IDLE
- live_keys → synth_keys latency: 1 cycle.
- Button edge → state change: 1 cycle after the registered edge (edge seen on the cycle btn rises; state/outputs update on the next edge).
- First step_tick: STEP_TICKS×(tempo_sel+1) cycles after entering RECORD/PLAY.
- In PLAY, synth_keys reflects the new step_idx on the cycle after step_tick.
- Reset asserted mid-record or mid-play returns all state immediately to the reset values.

## Configuration
- `SEQ_LIVE_OVERLAY_EN`:
  - Defined: in PLAY, synth_keys = mem[step_idx] | live_keys, so the player can play over the loop.
  - Undefined: in PLAY, synth_keys = mem[step_idx] only, and live_keys is ignored.
- IDLE and RECORD behaviour are unaffected by the macro.

## Structure
- Package `sss_seq_pkg` holds:
  - `seq_state_t` enum {IDLE, RECORD, PLAY}
  - `NUM_KEYS_DEF` = 17, `NUM_STEPS_DEF` = 16
- Sub-module `seq_step_timer`:
  - inputs: hwclk, reset, run, tempo_sel
  - parameter: STEP_TICKS
  - output: step_tick
- The pattern memory is a flop array inside `note_sequencer`, so it can be async-cleared.

## Test plan
All scenarios use STEP_TICKS = 4.

- Reset then live_keys = 17'h00005 → synth_keys = 17'h00005 one cycle later; recording = playing = 0.
- rec; hold 17'h00001 for step 0 and 17'h00010 for step 1; rec mid-step 2 with 17'h00100 held → pattern_len = 3, IDLE.
- Continue from the previous scenario: play, tempo_sel = 0 → synth_keys cycles 17'h00001, 17'h00010, 17'h00100, then wraps to 17'h00001; step_tick every 4 cycles.
- tempo_sel = 2 during PLAY → step_tick period becomes 12 cycles.
- Continue from the previous scenario: PLAY with live_keys = 17'h10000 → synth_keys shows the pattern | 17'h10000 with `SEQ_LIVE_OVERLAY_EN` defined, and the pattern alone without it.
- clr and rec in the same cycle during PLAY → IDLE, pattern_len = 0; a subsequent play press stays in IDLE.
